// File: rtl/window_buffer.sv
// window_buffer
//   Builds a sliding Ope_Size x Ope_Size pixel window over a raster-order
//   8-bit image stream. Previous lines are held in Ope_Size-1 line buffers.
//   The window shifts one column left on every accepted pixel. It is
//   flagged valid only when every element lies inside the current frame
//   and does not straddle a line wrap.
//
// Parameters
//   Ope_Size   : window edge length (odd, 3..7)
//   Img_Width  : pixels per line (>= Ope_Size)
//   Img_Height : lines per frame (>= Ope_Size)
//
// Ports
//   clk      : clock, all logic on the rising edge
//   rst      : synchronous active-high reset
//   reflesh  : synchronous active-high frame restart (same effect as rst)
//   pixel_in : [8] valid strobe, [7:0] pixel value
//   data_bus : registered window; element (y,x) is at [((y*Ope_Size)+x)*9 +: 9],
//              where bit 8 is window valid and bits 7:0 are the pixel value.
//              y=0 is the oldest line (top); x=0 is the oldest column (left).
module window_buffer #(
  parameter int Ope_Size   = 3,
  parameter int Img_Width  = 640,
  parameter int Img_Height = 480
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             reflesh,
  input  logic [8:0]                       pixel_in,
  output logic [9*Ope_Size*Ope_Size-1:0]   data_bus
);

  localparam int CW = (Img_Width  > 1) ? $clog2(Img_Width)  : 1;
  localparam int RW = (Img_Height > 1) ? $clog2(Img_Height) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(Img_Width - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(Img_Height - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(Ope_Size - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(Ope_Size - 1);

  logic clear;
  logic accept;

  // A restart cycle swallows any pixel presented alongside it.
  assign clear  = rst | reflesh;
  assign accept = pixel_in[8] & ~clear;

  // ---------------------------------------------------------------- counters
  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (clear) begin
      col_next = '0;
      row_next = '0;
    end else if (pixel_in[8]) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        if (row_reg == ROW_LAST) begin
          row_next = '0;
        end else begin
          row_next = row_reg + 1'b1;
        end
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || reflesh) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  // ------------------------------------------------------------ line buffers
  // Each buffer is a RAM with a registered read port. The read is
  // prefetched one cycle early using the column the counter is about to
  // hold. When the pixel for that column arrives, lb_rd already carries
  // the pre-write contents. The prefetch address never equals the column
  // being written in the same cycle, so the read always sees the old data.
  logic [7:0] lb_rd [Ope_Size-1];

  genvar gi, gj;
  generate
    for (gi = 0; gi < Ope_Size - 1; gi++) begin : gen_lb
      logic [7:0] mem [Img_Width];
      logic [7:0] wr_data;

      if (gi == 0) begin : gen_head
        assign wr_data = pixel_in[7:0];
      end else begin : gen_chain
        assign wr_data = lb_rd[gi-1];
      end

      always_ff @(posedge clk) begin
        if (accept) begin
          mem[col_reg] <= wr_data;
        end
        lb_rd[gi] <= mem[col_next];
      end
    end
  endgenerate

  // ------------------------------------------------------------------ window
  // Vertical slice entering the right-hand column. The oldest line is on
  // top, so row y takes the buffer that is (Ope_Size-2-y) lines deep.
  logic [7:0] col_in [Ope_Size];

  generate
    for (gi = 0; gi < Ope_Size - 1; gi++) begin : gen_col_in
      assign col_in[gi] = lb_rd[Ope_Size-2-gi];
    end
  endgenerate
  assign col_in[Ope_Size-1] = pixel_in[7:0];

  logic [7:0] win_reg [Ope_Size][Ope_Size];
  logic       valid_reg;

  always_ff @(posedge clk) begin
    if (rst || reflesh) begin
      valid_reg <= 1'b0;
      for (int y = 0; y < Ope_Size; y++) begin
        for (int x = 0; x < Ope_Size; x++) begin
          win_reg[y][x] <= '0;
        end
      end
    end else begin
      // Valid only once a full window of this frame and line is present;
      // windows straddling a line wrap have col < Ope_Size-1.
      valid_reg <= accept && (row_reg >= ROW_FIRST) && (col_reg >= COL_FIRST);
      if (accept) begin
        for (int y = 0; y < Ope_Size; y++) begin
          for (int x = 0; x < Ope_Size - 1; x++) begin
            win_reg[y][x] <= win_reg[y][x+1];
          end
          win_reg[y][Ope_Size-1] <= col_in[y];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < Ope_Size; gi++) begin : gen_row
      for (gj = 0; gj < Ope_Size; gj++) begin : gen_col
        assign data_bus[((gi*Ope_Size)+gj)*9 +: 9] = {valid_reg, win_reg[gi][gj]};
      end
    end
  endgenerate

endmodule

// File: tb/tb_window_buffer.sv
module tb_window_buffer;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int BW = 9 * N * N;
  localparam int WINDOWS_PER_FRAME = (W - N + 1) * (H - N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          reflesh;
  logic [8:0]    pixel_in;
  logic [BW-1:0] data_bus;

  window_buffer #(
    .Ope_Size  (N),
    .Img_Width (W),
    .Img_Height(H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .reflesh (reflesh),
    .pixel_in(pixel_in),
    .data_bus(data_bus)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: expected bus and which bits of it are meaningful.
  typedef struct {
    logic [BW-1:0] bus;
    logic [BW-1:0] mask;
    int            r;
    int            c;
    logic          acc;
  } exp_t;

  // Fixed taps checked in the window that follows pixel (2,2).
  typedef struct {
    int         y;
    int         x;
    logic [7:0] val;
  } tap_t;

  exp_t          sb_q[$];
  tap_t          taps[5];
  int            tests = 0;
  int            fails = 0;
  int            m_row = 0;
  int            m_col = 0;
  int            valid_cnt = 0;
  logic [BW-1:0] vmask;

  task automatic check_bus(input string name, input logic [BW-1:0] got,
                           input logic [BW-1:0] exp, input logic [BW-1:0] mask);
    tests++;
    if ((got & mask) !== (exp & mask)) begin
      fails++;
      $display("FAIL %s: got %h required %h (mask %h)", name, got, exp, mask);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // One clock: drive inputs, push the expectation, then compare 1 ns after
  // the capturing edge.
  task automatic drive(input logic v, input logic do_rst, input logic do_ref);
    exp_t       e;
    logic [7:0] val;
    string      name;
    val      = 8'(m_row * 16 + m_col);
    pixel_in = {v, v ? val : 8'($urandom)};
    rst      = do_rst;
    reflesh  = do_ref;
    e.r   = m_row;
    e.c   = m_col;
    e.bus = '0;
    e.acc = 1'b0;
    if (do_rst || do_ref) begin
      e.mask = '1;
      m_row  = 0;
      m_col  = 0;
    end else if (!v) begin
      e.mask = vmask;
    end else begin
      e.acc = 1'b1;
      if (m_row >= N - 1 && m_col >= N - 1) begin
        e.mask = '1;
        for (int y = 0; y < N; y++) begin
          for (int x = 0; x < N; x++) begin
            e.bus[((y*N)+x)*9 +: 9] =
              {1'b1, 8'((m_row - (N-1) + y) * 16 + (m_col - (N-1) + x))};
          end
        end
      end else begin
        e.mask = vmask;
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
    end
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (do_rst || do_ref) name = "restart";
    else if (!v)          name = "gap";
    else                  name = $sformatf("win(%0d,%0d)", e.r, e.c);
    check_bus(name, data_bus, e.bus, e.mask);
    if (data_bus[((N*N)/2)*9+8]) valid_cnt++;
    if (e.acc && e.r == 2 && e.c == 2) begin
      for (int t = 0; t < 5; t++) begin
        check_int($sformatf("tap d[%0d][%0d]", taps[t].y, taps[t].x),
                  int'(data_bus[((taps[t].y*N)+taps[t].x)*9 +: 8]),
                  int'(taps[t].val));
      end
      check_int("tap valid", int'(data_bus[8]), 1);
    end
  endtask

  task automatic run_pixels(input int count, input int gap_max);
    int gaps;
    for (int i = 0; i < count; i++) begin
      gaps = 0;
      if (gap_max > 0 && $urandom_range(0, 2) == 0) gaps = $urandom_range(1, gap_max);
      repeat (gaps) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic frame(input int gap_max);
    valid_cnt = 0;
    run_pixels(W * H, gap_max);
    check_int("frame valid count", valid_cnt, WINDOWS_PER_FRAME);
  endtask

  initial begin
    vmask = '0;
    for (int i = 0; i < N * N; i++) vmask[i*9+8] = 1'b1;
    taps[0] = '{y: 0, x: 0, val: 8'h00};
    taps[1] = '{y: 1, x: 1, val: 8'h11};
    taps[2] = '{y: 2, x: 2, val: 8'h22};
    taps[3] = '{y: 0, x: 2, val: 8'h02};
    taps[4] = '{y: 2, x: 0, val: 8'h20};

    pixel_in = '0;
    rst      = 1'b1;
    reflesh  = 1'b0;

    // Reset state
    repeat (2) drive(1'b0, 1'b1, 1'b0);

    // Two back-to-back gap-free frames, then one with random gaps
    frame(0);
    frame(0);
    frame(5);

    // Mid-frame reflesh after pixel (3,5), pixel on that cycle ignored
    run_pixels(3 * W + 6, 0);
    drive(1'b1, 1'b0, 1'b1);
    frame(0);

    // Same scenario with rst
    run_pixels(3 * W + 6, 2);
    drive(1'b1, 1'b1, 1'b0);
    frame(0);

    // Idle cycles: window must stay flagged invalid
    repeat (3) drive(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
